// File: rtl/exmem_pkg.sv
// Shared definitions for the EX/MEM stage register: control-bit positions inside the
// 6-bit ctrl bundle, the default-width entry layout, and an entry-width helper.
package exmem_pkg;

  localparam int unsigned CTRL_W        = 6;
  localparam int unsigned CTRL_MEMREAD  = 5;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_MEMTOREG = 3;
  localparam int unsigned CTRL_REGWRITE = 2;
  localparam int unsigned CTRL_PCSRC    = 1;
  localparam int unsigned CTRL_JTOPC    = 0;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;

  // Field order here is the packing order used by every stage instance.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_DATA_W-1:0] imm;
    logic [DEF_DATA_W-1:0] branch_addr;
    logic [DEF_DATA_W-1:0] jump_addr;
    logic [DEF_REG_AW-1:0] wreg;
    logic [CTRL_W-1:0]     ctrl;
  } exmem_entry_t;

  function automatic int unsigned entry_w(int unsigned data_w, int unsigned reg_aw);
    return 4 * data_w + reg_aw + CTRL_W;
  endfunction

endpackage

// File: rtl/exmem_entry_reg.sv
// One valid bit plus payload, updated on the falling clock edge. Clear wins over load
// for the valid bit; the payload only changes on load and is zeroed by reset.
module exmem_entry_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end
      if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/exmem_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake, flush, redirect and forward taps.
// Define EXMEM_SKID_EN for a two-entry (main + skid) buffer with a registered in_ready.
module exmem_stage_reg
  import exmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_branch_addr,
  input  logic [DATA_W-1:0] in_jump_addr,
  input  logic [REG_AW-1:0] in_wreg,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_wreg,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] branch_addr;
    logic [DATA_W-1:0] jump_addr;
    logic [REG_AW-1:0] wreg;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  localparam int unsigned EntryW = entry_w(DATA_W, REG_AW);

  entry_t            in_entry;
  entry_t            head;
  logic [EntryW-1:0] m_d;
  logic [EntryW-1:0] m_q;
  logic              m_valid;
  logic              m_load;
  logic              m_clear;
  logic              accept;
  logic              pop;

  assign in_entry = '{alu: in_alu, imm: in_imm, branch_addr: in_branch_addr,
                      jump_addr: in_jump_addr, wreg: in_wreg, ctrl: in_ctrl};
  assign head     = entry_t'(m_q);
  assign pop      = m_valid && out_ready;
  assign accept   = in_valid && in_ready && !flush;

`ifdef EXMEM_SKID_EN
  logic [EntryW-1:0] s_q;
  logic              s_valid;
  logic              s_load;
  logic              s_clear;

  // Skid is only ever occupied while main is, so !s_valid means a free slot.
  assign in_ready = !s_valid;

  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    m_d     = in_entry;
    s_load  = 1'b0;
    s_clear = flush;
    if (flush) begin
      m_clear = 1'b1;
    end else if (pop) begin
      if (s_valid) begin
        m_load  = 1'b1;
        m_d     = s_q;
        s_clear = 1'b1;
      end else if (accept) begin
        m_load = 1'b1;
      end else begin
        m_clear = 1'b1;
      end
    end else if (accept) begin
      if (m_valid) begin
        s_load = 1'b1;
      end else begin
        m_load = 1'b1;
      end
    end
  end

  exmem_entry_reg #(.W(EntryW)) u_skid (
    .clk   (CLK),
    .rst_n (RSTn),
    .load  (s_load),
    .clear (s_clear),
    .d     (in_entry),
    .valid (s_valid),
    .q     (s_q)
  );
`else
  assign in_ready = !m_valid || out_ready;
  assign m_load   = accept;
  assign m_clear  = flush || (pop && !accept);
  assign m_d      = in_entry;
`endif

  exmem_entry_reg #(.W(EntryW)) u_main (
    .clk   (CLK),
    .rst_n (RSTn),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .valid (m_valid),
    .q     (m_q)
  );

  assign out_valid    = m_valid;
  assign out_alu      = head.alu;
  assign out_imm      = head.imm;
  assign out_wreg     = head.wreg;
  assign out_memread  = head.ctrl[CTRL_MEMREAD] && m_valid;
  assign out_memwrite = head.ctrl[CTRL_MEMWRITE] && m_valid;
  assign out_memtoreg = head.ctrl[CTRL_MEMTOREG];
  assign out_regwrite = head.ctrl[CTRL_REGWRITE] && m_valid;

  // Jump takes priority over branch when both are flagged.
  assign redirect_valid = m_valid && (head.ctrl[CTRL_PCSRC] || head.ctrl[CTRL_JTOPC]);
  assign redirect_pc    = head.ctrl[CTRL_JTOPC] ? head.jump_addr : head.branch_addr;

  // Loads (MemtoReg) are not ready until MEM, and $0 is hardwired zero.
  assign fwd_valid = m_valid && head.ctrl[CTRL_REGWRITE] && !head.ctrl[CTRL_MEMTOREG] &&
                     (head.wreg != '0);
  assign fwd_addr  = head.wreg;
  assign fwd_data  = head.alu;

endmodule

// File: tb/tb_exmem_stage_reg.sv
// Scoreboard bench for exmem_stage_reg: stimulus pushes accepted instructions into a
// queue, a monitor compares the head outputs against the queue front every cycle.
module tb_exmem_stage_reg;
  import exmem_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          CLK = 1'b1;
  logic          RSTn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_alu = '0;
  logic [DW-1:0] in_imm = '0;
  logic [DW-1:0] in_branch_addr = '0;
  logic [DW-1:0] in_jump_addr = '0;
  logic [AW-1:0] in_wreg = '0;
  logic [5:0]    in_ctrl = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_alu;
  logic [DW-1:0] out_imm;
  logic [AW-1:0] out_wreg;
  logic          out_memread;
  logic          out_memwrite;
  logic          out_memtoreg;
  logic          out_regwrite;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;

  exmem_stage_reg #(.DATA_W(DW), .REG_AW(AW)) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu         (in_alu),
    .in_imm         (in_imm),
    .in_branch_addr (in_branch_addr),
    .in_jump_addr   (in_jump_addr),
    .in_wreg        (in_wreg),
    .in_ctrl        (in_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu        (out_alu),
    .out_imm        (out_imm),
    .out_wreg       (out_wreg),
    .out_memread    (out_memread),
    .out_memwrite   (out_memwrite),
    .out_memtoreg   (out_memtoreg),
    .out_regwrite   (out_regwrite),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fwd_valid      (fwd_valid),
    .fwd_addr       (fwd_addr),
    .fwd_data       (fwd_data)
  );

  always #5 CLK = ~CLK;

  exmem_entry_t sb[$];
  int           total = 0;
  int           bad = 0;
  logic         mdl_ready = 1'b1;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, " out_valid"}, out_valid, 1'b0);
    chk1({tag, " redirect_valid"}, redirect_valid, 1'b0);
    chk1({tag, " fwd_valid"}, fwd_valid, 1'b0);
    chk1({tag, " memread"}, out_memread, 1'b0);
    chk1({tag, " memwrite"}, out_memwrite, 1'b0);
    chk1({tag, " memtoreg"}, out_memtoreg, 1'b0);
    chk1({tag, " regwrite"}, out_regwrite, 1'b0);
    chk32({tag, " out_alu"}, out_alu, 32'h0);
    chk32({tag, " out_imm"}, out_imm, 32'h0);
    chk32({tag, " out_wreg"}, 32'(out_wreg), 32'h0);
    chk32({tag, " redirect_pc"}, redirect_pc, 32'h0);
    chk32({tag, " fwd_addr"}, 32'(fwd_addr), 32'h0);
    chk32({tag, " fwd_data"}, fwd_data, 32'h0);
  endtask

  // Monitor: runs 3 time units after each rising edge, before the falling (active) edge.
  initial begin
    exmem_entry_t e;
    logic         jump;
    logic         branch;
    forever begin
      @(posedge CLK);
      #3;
      if (!RSTn) begin
        sb.delete();
        mdl_ready = 1'b0;
      end else begin
`ifdef EXMEM_SKID_EN
        mdl_ready = (sb.size() < 2);
`else
        mdl_ready = (sb.size() == 0) || out_ready;
`endif
        if (!(flush && in_valid)) chk1("in_ready", in_ready, mdl_ready);
        chk1("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
          e      = sb[0];
          jump   = e.ctrl[0];
          branch = e.ctrl[1];
          chk32("out_alu", out_alu, e.alu);
          chk32("out_imm", out_imm, e.imm);
          chk32("out_wreg", 32'(out_wreg), 32'(e.wreg));
          chk1("memread", out_memread, e.ctrl[5]);
          chk1("memwrite", out_memwrite, e.ctrl[4]);
          chk1("memtoreg", out_memtoreg, e.ctrl[3]);
          chk1("regwrite", out_regwrite, e.ctrl[2]);
          chk1("redirect_valid", redirect_valid, jump | branch);
          chk32("redirect_pc", redirect_pc, jump ? e.jump_addr : e.branch_addr);
          chk1("fwd_valid", fwd_valid, e.ctrl[2] && !e.ctrl[3] && (e.wreg != 5'd0));
          chk32("fwd_addr", 32'(fwd_addr), 32'(e.wreg));
          chk32("fwd_data", fwd_data, e.alu);
          if (out_ready) void'(sb.pop_front());
        end else begin
          chk1("idle memread", out_memread, 1'b0);
          chk1("idle memwrite", out_memwrite, 1'b0);
          chk1("idle regwrite", out_regwrite, 1'b0);
          chk1("idle redirect_valid", redirect_valid, 1'b0);
          chk1("idle fwd_valid", fwd_valid, 1'b0);
        end
        if (flush) sb.delete();
      end
    end
  end

  function automatic exmem_entry_t mk(input logic [31:0] alu, input logic [5:0] ctrl,
                                      input logic [4:0] wreg, input logic [31:0] ba,
                                      input logic [31:0] ja);
    exmem_entry_t e;
    e.alu         = alu;
    e.imm         = ~alu;
    e.branch_addr = ba;
    e.jump_addr   = ja;
    e.wreg        = wreg;
    e.ctrl        = ctrl;
    return e;
  endfunction

  function automatic exmem_entry_t rnd_entry();
    exmem_entry_t e;
    e.alu         = $urandom;
    e.imm         = $urandom;
    e.branch_addr = $urandom;
    e.jump_addr   = $urandom;
    e.wreg        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    e.ctrl        = 6'($urandom);
    return e;
  endfunction

  // One cycle of stimulus; the accept decision comes from the monitor's model of in_ready.
  task automatic step(input logic v, input logic rdy, input logic fl, input exmem_entry_t e);
    @(posedge CLK);
    #1;
    in_valid       = v;
    out_ready      = rdy;
    flush          = fl;
    in_alu         = e.alu;
    in_imm         = e.imm;
    in_branch_addr = e.branch_addr;
    in_jump_addr   = e.jump_addr;
    in_wreg        = e.wreg;
    in_ctrl        = e.ctrl;
    #3;
    if (RSTn && v && !fl && mdl_ready) sb.push_back(e);
  endtask

  task automatic mid_reset();
    @(posedge CLK);
    #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    RSTn = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(posedge CLK);
    #2;
    RSTn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exmem_entry_t idle;
    idle = mk(32'h0, 6'h0, 5'd0, 32'h0, 32'h0);

    #7;
    chk_zero("reset");
    @(posedge CLK);
    #2;
    RSTn = 1'b1;

    // Streaming
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, mk(32'h10 + i, 6'b000100, 5'd3, 0, 0));
    repeat (2) step(1'b0, 1'b1, 1'b0, idle);

    // Stall with DEAD at head and BEEF waiting
    step(1'b1, 1'b1, 1'b0, mk(32'hDEAD, 6'b000100, 5'd4, 0, 0));
    repeat (3) step(1'b1, 1'b0, 1'b0, mk(32'hBEEF, 6'b000100, 5'd5, 0, 0));
    step(1'b1, 1'b1, 1'b0, mk(32'hBEEF, 6'b000100, 5'd5, 0, 0));
    repeat (3) step(1'b0, 1'b1, 1'b0, idle);

    // Flush with a store held and a new instruction arriving
    step(1'b1, 1'b0, 1'b0, mk(32'hA0, 6'b010000, 5'd0, 0, 0));
    step(1'b1, 1'b0, 1'b0, mk(32'hA1, 6'b010000, 5'd1, 0, 0));
    step(1'b1, 1'b0, 1'b1, mk(32'hBAD, 6'b010100, 5'd9, 0, 0));
    repeat (2) step(1'b0, 1'b1, 1'b0, idle);

    // Redirect priority and forwarding rules
    step(1'b1, 1'b1, 1'b0, mk(32'h1, 6'b000011, 5'd1, 32'h100, 32'h200));
    step(1'b1, 1'b1, 1'b0, mk(32'h2, 6'b000010, 5'd1, 32'h100, 32'h200));
    step(1'b1, 1'b1, 1'b0, mk(32'h3, 6'b000100, 5'd0, 0, 0));
    step(1'b1, 1'b1, 1'b0, mk(32'h55, 6'b000100, 5'd7, 0, 0));
    step(1'b1, 1'b1, 1'b0, mk(32'h66, 6'b001100, 5'd7, 0, 0));
    repeat (2) step(1'b0, 1'b1, 1'b0, idle);

    // Reset while stalled with entries held
    step(1'b1, 1'b1, 1'b0, mk(32'hC0, 6'b110100, 5'd2, 0, 0));
    step(1'b1, 1'b0, 1'b0, mk(32'hC1, 6'b110100, 5'd2, 0, 0));
    step(1'b1, 1'b0, 1'b0, mk(32'hC2, 6'b110100, 5'd2, 0, 0));
    mid_reset();
    repeat (2) step(1'b0, 1'b1, 1'b0, idle);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
           rnd_entry());
    end
    repeat (4) step(1'b0, 1'b1, 1'b0, idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
